// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - forwarding, stall/flush and long-op scoreboard for a 5-stage pipeline
// Optional stall/flush cycle counters are enabled with `define HAZARD_STALL_STATS_EN.
module hazard_scoreboard #(
    parameter int REG_AW     = 5,
    parameter int LONG_LAT   = 4,
    parameter int LONG_SLOTS = 2,
    parameter int CNT_W      = $clog2(LONG_LAT) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] Rs1D,
    input  logic [REG_AW-1:0] Rs2D,
    input  logic [REG_AW-1:0] RdD,
    input  logic              RegWriteD,
    input  logic              BranchD,
    input  logic              LongD,
    input  logic              PCSrcD,
    input  logic [REG_AW-1:0] Rs1E,
    input  logic [REG_AW-1:0] Rs2E,
    input  logic [REG_AW-1:0] RdE,
    input  logic              RegWriteE,
    input  logic              ResultSrcE,
    input  logic              IssueLongE,
    input  logic [REG_AW-1:0] RdM,
    input  logic [REG_AW-1:0] RdW,
    input  logic              RegWriteM,
    input  logic              ResultSrcM,
    input  logic              RegWriteW,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              ForwardAD,
    output logic              ForwardBD,
    output logic              StallF,
    output logic              StallD,
    output logic              FlushD,
    output logic              FlushE,
    output logic              LongWbValid,
    output logic [REG_AW-1:0] LongWbRd,
`ifdef HAZARD_STALL_STATS_EN
    output logic [31:0]       stall_cycles,
    output logic [31:0]       flush_cycles,
`endif
    output logic              LongBusy
);

    localparam int NREG = 1 << REG_AW;

    logic [LONG_SLOTS-1:0] valid_q, valid_d;
    logic [REG_AW-1:0]     rd_q  [LONG_SLOTS];
    logic [REG_AW-1:0]     rd_d  [LONG_SLOTS];
    logic [CNT_W-1:0]      cnt_q [LONG_SLOTS];
    logic [CNT_W-1:0]      cnt_d [LONG_SLOTS];
    logic [NREG-1:0]       pending_q, pending_d;
    logic [LONG_SLOTS-1:0] issue_sel;
    logic                  issue_en, found;
    logic                  m_hit_e1, m_hit_e2, w_hit_e1, w_hit_e2;
    logic                  lw_stall, br_stall, sb_stall, stall;

    assign m_hit_e1 = RegWriteM && (RdM != '0) && (RdM == Rs1E);
    assign m_hit_e2 = RegWriteM && (RdM != '0) && (RdM == Rs2E);
    assign w_hit_e1 = RegWriteW && (RdW != '0) && (RdW == Rs1E);
    assign w_hit_e2 = RegWriteW && (RdW != '0) && (RdW == Rs2E);

    assign ForwardAE = m_hit_e1 ? 2'b10 : (w_hit_e1 ? 2'b01 : 2'b00);
    assign ForwardBE = m_hit_e2 ? 2'b10 : (w_hit_e2 ? 2'b01 : 2'b00);
    assign ForwardAD = RegWriteM && (RdM != '0) && (RdM == Rs1D);
    assign ForwardBD = RegWriteM && (RdM != '0) && (RdM == Rs2D);

    assign LongBusy = &valid_q;

    assign lw_stall = ResultSrcE && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));
    assign br_stall = BranchD &&
        ((RegWriteE && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D))) ||
         (ResultSrcM && (RdM != '0) && ((RdM == Rs1D) || (RdM == Rs2D))));
    assign sb_stall = pending_q[Rs1D] || pending_q[Rs2D] ||
                      (RegWriteD && pending_q[RdD]) || (LongD && LongBusy);
    assign stall    = lw_stall | br_stall | sb_stall;

    assign StallF = stall;
    assign StallD = stall;
    assign FlushE = stall;
    assign FlushD = PCSrcD && !stall;

    // Fixed latency with single issue guarantees at most one slot reaches zero per cycle.
    always_comb begin
        LongWbValid = 1'b0;
        LongWbRd    = '0;
        for (int i = 0; i < LONG_SLOTS; i++) begin
            if (valid_q[i] && (cnt_q[i] == '0)) begin
                LongWbValid = 1'b1;
                LongWbRd    = rd_q[i];
            end
        end
    end

    assign issue_en = IssueLongE && (RdE != '0) && !LongBusy;

    always_comb begin
        issue_sel = '0;
        found     = 1'b0;
        for (int i = 0; i < LONG_SLOTS; i++) begin
            if (issue_en && !valid_q[i] && !found) begin
                issue_sel[i] = 1'b1;
                found        = 1'b1;
            end
        end
    end

    // A slot completing this cycle is still valid, so it cannot be chosen until the next cycle.
    always_comb begin
        valid_d = valid_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;
        for (int i = 0; i < LONG_SLOTS; i++) begin
            if (valid_q[i]) begin
                if (cnt_q[i] == '0) valid_d[i] = 1'b0;
                else                cnt_d[i]   = cnt_q[i] - CNT_W'(1);
            end
            if (issue_sel[i]) begin
                valid_d[i] = 1'b1;
                rd_d[i]    = RdE;
                cnt_d[i]   = CNT_W'(LONG_LAT - 1);
            end
        end
    end

    always_comb begin
        pending_d = pending_q;
        if (LongWbValid) pending_d[LongWbRd] = 1'b0;
        if (issue_en)    pending_d[RdE]      = 1'b1;
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q   <= '0;
            pending_q <= '0;
            for (int i = 0; i < LONG_SLOTS; i++) begin
                rd_q[i]  <= '0;
                cnt_q[i] <= '0;
            end
        end else begin
            valid_q   <= valid_d;
            pending_q <= pending_d;
            rd_q      <= rd_d;
            cnt_q     <= cnt_d;
        end
    end

`ifdef HAZARD_STALL_STATS_EN
    logic [31:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

    assign stall_cnt_d = (stall  && (stall_cnt_q != '1)) ? stall_cnt_q + 32'd1 : stall_cnt_q;
    assign flush_cnt_d = (FlushD && (flush_cnt_q != '1)) ? flush_cnt_q + 32'd1 : flush_cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cycles = stall_cnt_q;
    assign flush_cycles = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - directed and randomized checks of hazard_scoreboard against a queue model
module tb_hazard_scoreboard;

    localparam int AW  = 5;
    localparam int LAT = 4;
    localparam int SL  = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] Rs1D, Rs2D, RdD, Rs1E, Rs2E, RdE, RdM, RdW;
    logic          RegWriteD, BranchD, LongD, PCSrcD;
    logic          RegWriteE, ResultSrcE, IssueLongE;
    logic          RegWriteM, ResultSrcM, RegWriteW;
    logic [1:0]    ForwardAE, ForwardBE;
    logic          ForwardAD, ForwardBD, StallF, StallD, FlushD, FlushE;
    logic          LongWbValid, LongBusy;
    logic [AW-1:0] LongWbRd;
`ifdef HAZARD_STALL_STATS_EN
    logic [31:0]   stall_cycles, flush_cycles;
    int            m_stall_cnt, m_flush_cnt;
`endif

    hazard_scoreboard #(.REG_AW(AW), .LONG_LAT(LAT), .LONG_SLOTS(SL)) dut (
        .clk(clk), .reset(reset),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
        .RegWriteD(RegWriteD), .BranchD(BranchD), .LongD(LongD), .PCSrcD(PCSrcD),
        .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .IssueLongE(IssueLongE),
        .RdM(RdM), .RdW(RdW),
        .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .RegWriteW(RegWriteW),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
        .LongWbValid(LongWbValid), .LongWbRd(LongWbRd),
`ifdef HAZARD_STALL_STATS_EN
        .stall_cycles(stall_cycles), .flush_cycles(flush_cycles),
`endif
        .LongBusy(LongBusy)
    );

    always #5 clk = ~clk;

    typedef struct { int rd; int wb; } op_t;
    op_t mq[$];
    int  cyc;
    int  checks;
    int  errors;
    bit  exp_stall, exp_flushd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic bit m_pending(input int r);
        if (r == 0) return 1'b0;
        foreach (mq[i]) if (mq[i].rd == r) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_busy();
        return mq.size() >= SL;
    endfunction

    function automatic int fwd_e(input int rs);
        if (RegWriteM && RdM != 0 && int'(RdM) == rs) return 2;
        if (RegWriteW && RdW != 0 && int'(RdW) == rs) return 1;
        return 0;
    endfunction

    task automatic check_outputs();
        bit lw, br, sb, wbv;
        int wbrd;
        lw = ResultSrcE && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
        br = BranchD && ((RegWriteE && RdE != 0 && (RdE == Rs1D || RdE == Rs2D)) ||
                         (ResultSrcM && RdM != 0 && (RdM == Rs1D || RdM == Rs2D)));
        sb = m_pending(int'(Rs1D)) || m_pending(int'(Rs2D)) ||
             (RegWriteD && m_pending(int'(RdD))) || (LongD && m_busy());
        exp_stall  = lw | br | sb;
        exp_flushd = PCSrcD && !exp_stall;
        wbv = 1'b0; wbrd = 0;
        foreach (mq[i]) if (mq[i].wb == cyc) begin wbv = 1'b1; wbrd = mq[i].rd; end
        chk("ForwardAE", 32'(ForwardAE), 32'(fwd_e(int'(Rs1E))));
        chk("ForwardBE", 32'(ForwardBE), 32'(fwd_e(int'(Rs2E))));
        chk("ForwardAD", 32'(ForwardAD), 32'(RegWriteM && RdM != 0 && RdM == Rs1D));
        chk("ForwardBD", 32'(ForwardBD), 32'(RegWriteM && RdM != 0 && RdM == Rs2D));
        chk("StallF", 32'(StallF), 32'(exp_stall));
        chk("StallD", 32'(StallD), 32'(exp_stall));
        chk("FlushE", 32'(FlushE), 32'(exp_stall));
        chk("FlushD", 32'(FlushD), 32'(exp_flushd));
        chk("LongWbValid", 32'(LongWbValid), 32'(wbv));
        chk("LongWbRd", 32'(LongWbRd), 32'(wbrd));
        chk("LongBusy", 32'(LongBusy), 32'(m_busy()));
`ifdef HAZARD_STALL_STATS_EN
        chk("stall_cycles", stall_cycles, 32'(m_stall_cnt));
        chk("flush_cycles", flush_cycles, 32'(m_flush_cnt));
`endif
    endtask

    task automatic model_edge();
        if (!reset) begin
            mq.delete();
`ifdef HAZARD_STALL_STATS_EN
            m_stall_cnt = 0; m_flush_cnt = 0;
`endif
        end else begin
            if (IssueLongE && RdE != 0 && m_busy()) begin
                checks++; errors++;
                $error("FAIL issue_while_busy observed=1 expected=0 (cycle %0d)", cyc);
            end
            for (int i = mq.size() - 1; i >= 0; i--) if (mq[i].wb == cyc) mq.delete(i);
            if (IssueLongE && RdE != 0) mq.push_back('{rd: int'(RdE), wb: cyc + LAT});
`ifdef HAZARD_STALL_STATS_EN
            m_stall_cnt += int'(exp_stall);
            m_flush_cnt += int'(exp_flushd);
`endif
        end
        cyc++;
    endtask

    task automatic settle();
        #4 check_outputs();
    endtask

    task automatic adv();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        {Rs1D, Rs2D, RdD, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
        {RegWriteD, BranchD, LongD, PCSrcD, RegWriteE, ResultSrcE, IssueLongE} = '0;
        {RegWriteM, ResultSrcM, RegWriteW} = '0;
    endtask

    initial begin
        checks = 0; errors = 0; cyc = 0;
`ifdef HAZARD_STALL_STATS_EN
        m_stall_cnt = 0; m_flush_cnt = 0;
`endif
        idle_inputs();
        reset = 1'b0;
        @(posedge clk); #1;
        settle(); adv();
        settle(); chk("reset_LongWbRd", 32'(LongWbRd), 32'd0); adv();
        reset = 1'b1;

        // Forwarding priority
        RegWriteM = 1; RdM = 5; RegWriteW = 1; RdW = 5; Rs1E = 5;
        settle(); chk("fwd_m_prio", 32'(ForwardAE), 32'd2); adv();
        RegWriteM = 0;
        settle(); chk("fwd_w", 32'(ForwardAE), 32'd1); adv();
        RegWriteM = 1; RdM = 0; RdW = 0;
        settle(); chk("fwd_x0", 32'(ForwardAE), 32'd0); adv();
        idle_inputs();

        // Load-use stall then W forwarding
        ResultSrcE = 1; RdE = 3; Rs2D = 3;
        settle(); chk("lw_stall", 32'(StallD), 32'd1); chk("lw_flushd", 32'(FlushD), 32'd0); adv();
        idle_inputs(); RegWriteW = 1; RdW = 3; Rs2E = 3;
        settle(); chk("lw_after", 32'(StallD), 32'd0); chk("lw_fwdbe", 32'(ForwardBE), 32'd1); adv();
        idle_inputs();

        // Branch stall, then decode forwarding, then taken-branch flush
        BranchD = 1; RegWriteE = 1; RdE = 7; Rs1D = 7;
        settle(); chk("br_stall", 32'(StallF), 32'd1); adv();
        RegWriteE = 0; RdE = 0; RegWriteM = 1; RdM = 7;
        settle(); chk("br_fwdad", 32'(ForwardAD), 32'd1); chk("br_nostall", 32'(StallD), 32'd0); adv();
        idle_inputs(); PCSrcD = 1;
        settle(); chk("flushd", 32'(FlushD), 32'd1); adv();
        idle_inputs();

        // Long op latency
        IssueLongE = 1; RdE = 9;
        settle(); adv();
        idle_inputs(); Rs1D = 9;
        for (int k = 1; k <= LAT; k++) begin
            settle();
            chk("long_stall", 32'(StallD), 32'd1);
            chk("long_wbv", 32'(LongWbValid), 32'(k == LAT));
            adv();
        end
        settle(); chk("long_release", 32'(StallD), 32'd0); adv();
        idle_inputs();

        // Slot exhaustion and WAW
        IssueLongE = 1; RdE = 10; settle(); adv();
        RdE = 11; settle(); adv();
        idle_inputs(); LongD = 1;
        settle(); chk("busy", 32'(LongBusy), 32'd1); chk("busy_stall", 32'(StallD), 32'd1); adv();
        LongD = 0; RegWriteD = 1; RdD = 11;
        settle(); chk("waw_stall", 32'(StallD), 32'd1); adv();
        idle_inputs(); LongD = 1;
        for (int k = 0; k < LAT; k++) begin settle(); adv(); end
        idle_inputs();
        for (int k = 0; k < LAT; k++) begin settle(); adv(); end

        // Issue of the same rd in its completion cycle keeps it pending
        IssueLongE = 1; RdE = 12; settle(); adv();
        idle_inputs();
        for (int k = 1; k < LAT; k++) begin settle(); adv(); end
        IssueLongE = 1; RdE = 12;
        settle(); chk("collide_wbv", 32'(LongWbValid), 32'd1); adv();
        idle_inputs(); Rs1D = 12;
        settle(); chk("collide_pending", 32'(StallD), 32'd1); adv();
        idle_inputs();
        for (int k = 0; k < LAT; k++) begin settle(); adv(); end

        // Reset with two ops in flight
        IssueLongE = 1; RdE = 13; settle(); adv();
        RdE = 14; settle(); adv();
        idle_inputs(); Rs1D = 13; Rs2D = 14;
        #2 reset = 1'b0;
        mq.delete();
`ifdef HAZARD_STALL_STATS_EN
        m_stall_cnt = 0; m_flush_cnt = 0;
`endif
        #2 check_outputs();
        chk("rst_pending", 32'(StallD), 32'd0);
        adv();
        reset = 1'b1;
        for (int k = 0; k < LAT + 2; k++) begin
            settle(); chk("rst_no_wb", 32'(LongWbValid), 32'd0); adv();
        end

        // Randomized traffic with pipeline discipline on long issue
        for (int n = 0; n < 500; n++) begin
            Rs1D = AW'($urandom_range(0, 7)); Rs2D = AW'($urandom_range(0, 7));
            RdD  = AW'($urandom_range(0, 7));
            Rs1E = AW'($urandom_range(0, 7)); Rs2E = AW'($urandom_range(0, 7));
            RdE  = AW'($urandom_range(0, 7));
            RdM  = AW'($urandom_range(0, 7)); RdW  = AW'($urandom_range(0, 7));
            RegWriteD = 1'($urandom); BranchD = 1'($urandom); LongD = 1'($urandom);
            PCSrcD = 1'($urandom); RegWriteE = 1'($urandom);
            ResultSrcE = ($urandom_range(0, 3) == 0); RegWriteM = 1'($urandom);
            ResultSrcM = ($urandom_range(0, 3) == 0); RegWriteW = 1'($urandom);
            IssueLongE = ($urandom_range(0, 2) == 0) && !m_busy() && !m_pending(int'(RdE));
            settle(); adv();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
